// File: rtl/uart_frame_rx_if.sv
// Handshake bundle of uart_frame_rx: RX byte queue, 32-bit word FIFO, status and TX ack queue.
// master: the frame receiver. slave: the surrounding queues/FIFO (or a testbench).
interface uart_frame_rx_if;
  logic [7:0]  rxq_data;
  logic        rxq_empty;
  logic        deq_rxq;
  logic [31:0] word_data;
  logic        word_valid;
  logic        word_ready;
  logic        frame_ok;
  logic        frame_err;
  logic [1:0]  err_code;
  logic        busy;
  logic        enq_txq;
  logic [7:0]  txq_data;
  logic        txq_full;

  modport master (
    input  rxq_data, rxq_empty, word_ready, txq_full,
    output deq_rxq, word_data, word_valid, frame_ok, frame_err, err_code, busy,
           enq_txq, txq_data
  );

  modport slave (
    output rxq_data, rxq_empty, word_ready, txq_full,
    input  deq_rxq, word_data, word_valid, frame_ok, frame_err, err_code, busy,
           enq_txq, txq_data
  );
endinterface

// File: rtl/uart_frame_rx.sv
// uart_frame_rx: hunts SYNC0/SYNC1, reads a word-count byte, buffers the big-endian payload
// words, verifies an 8-bit additive checksum and only then drains the words downstream.
// Optional macro UART_FRAME_ACK_EN: after each good/rejected frame push one ack byte to the
// TX queue (8'h06 on success, {6'b111000, err_code} on error).
module uart_frame_rx #(
  parameter int unsigned MAX_WORDS      = 64,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter logic [7:0]  SYNC0          = 8'hA5,
  parameter logic [7:0]  SYNC1          = 8'h5A
) (
  input logic             i_clk,
  input logic             i_rst,
  uart_frame_rx_if.master bus
);
  localparam int unsigned LenW = $clog2(MAX_WORDS + 1);
  localparam int unsigned IdxW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam int unsigned GapW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [8:0]      MaxLen   = 9'(MAX_WORDS);
  localparam logic [GapW-1:0] GapLimit = GapW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    StHunt0, StHunt1, StLen, StPayload, StChk, StDrain, StAck
  } state_e;

`ifdef UART_FRAME_ACK_EN
  localparam state_e StDone = StAck;
`else
  localparam state_e StDone = StHunt0;
`endif

  state_e            state_q, state_d;
  logic [LenW-1:0]   len_q, len_d;
  logic [LenW-1:0]   wr_idx_q, wr_idx_d;
  logic [LenW-1:0]   rd_idx_q, rd_idx_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [23:0]       asm_q, asm_d;
  logic [7:0]        chk_q, chk_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic              ok_q, ok_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [31:0]       buf_q [MAX_WORDS];
  logic              buf_we;
  logic [31:0]       buf_wdata;
  logic              rx_state, consume, fail, done;
  logic [1:0]        fail_code;
`ifdef UART_FRAME_ACK_EN
  logic              ack_ok_q, ack_ok_d;
`endif

  // Bytes are only taken while hunting or inside a frame; DRAIN/ACK back-pressure the RX queue.
  assign rx_state = state_q inside {StHunt0, StHunt1, StLen, StPayload, StChk};
  assign consume  = rx_state && !bus.rxq_empty && !i_rst;

  // Next-state, datapath updates and error/completion detection.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    wr_idx_d   = wr_idx_q;
    rd_idx_d   = rd_idx_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    chk_d      = chk_q;
    gap_d      = gap_q;
    ok_d       = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    buf_we     = 1'b0;
    buf_wdata  = {asm_q, bus.rxq_data};
    fail       = 1'b0;
    fail_code  = 2'd0;
    done       = 1'b0;
`ifdef UART_FRAME_ACK_EN
    ack_ok_d   = ack_ok_q;
`endif
    unique case (state_q)
      StHunt0: if (consume && bus.rxq_data == SYNC0) state_d = StHunt1;
      StHunt1: begin
        if (consume) begin
          if (bus.rxq_data == SYNC1) state_d = StLen;
          else if (bus.rxq_data != SYNC0) state_d = StHunt0;
        end
      end
      StLen: begin
        if (consume) begin
          if (bus.rxq_data == 8'h00 || {1'b0, bus.rxq_data} > MaxLen) begin
            fail      = 1'b1;
            fail_code = 2'd1;
          end else begin
            len_d      = bus.rxq_data[LenW-1:0];
            chk_d      = bus.rxq_data;
            wr_idx_d   = '0;
            byte_cnt_d = '0;
            state_d    = StPayload;
          end
        end
      end
      StPayload: begin
        if (consume) begin
          chk_d      = chk_q + bus.rxq_data;
          asm_d      = {asm_q[15:0], bus.rxq_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            buf_we   = 1'b1;
            wr_idx_d = wr_idx_q + LenW'(1);
            if (wr_idx_d == len_q) state_d = StChk;
          end
        end
      end
      StChk: begin
        if (consume) begin
          if (bus.rxq_data == chk_q) begin
            state_d  = StDrain;
            rd_idx_d = '0;
          end else begin
            fail      = 1'b1;
            fail_code = 2'd2;
          end
        end
      end
      StDrain: begin
        if (bus.word_ready) begin
          if (rd_idx_q + LenW'(1) == len_q) done = 1'b1;
          else rd_idx_d = rd_idx_q + LenW'(1);
        end
      end
      StAck: if (!bus.txq_full) state_d = StHunt0;
      default: state_d = StHunt0;
    endcase

    // Inter-byte gap watchdog, armed only between SYNC1 and CHK.
    if (state_q inside {StLen, StPayload, StChk}) begin
      if (consume) begin
        gap_d = '0;
      end else begin
        gap_d = gap_q + GapW'(1);
        if (gap_d == GapLimit) begin
          fail      = 1'b1;
          fail_code = 2'd3;
        end
      end
    end else begin
      gap_d = '0;
    end

    if (fail) begin
      state_d    = StDone;
      err_d      = 1'b1;
      err_code_d = fail_code;
    end
    if (done) begin
      state_d = StDone;
      ok_d    = 1'b1;
    end
`ifdef UART_FRAME_ACK_EN
    if (fail) ack_ok_d = 1'b0;
    if (done) ack_ok_d = 1'b1;
`endif
  end

  // State and control registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StHunt0;
      len_q      <= '0;
      wr_idx_q   <= '0;
      rd_idx_q   <= '0;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      chk_q      <= '0;
      gap_q      <= '0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      chk_q      <= chk_d;
      gap_q      <= gap_d;
      ok_q       <= ok_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

`ifdef UART_FRAME_ACK_EN
  // Remembers which ack byte the ACK state must send.
  always_ff @(posedge i_clk) begin
    if (i_rst) ack_ok_q <= 1'b0;
    else ack_ok_q <= ack_ok_d;
  end
`endif

  // Word buffer; contents are don't-care until written, so it has no reset.
  always_ff @(posedge i_clk) begin
    if (buf_we) buf_q[wr_idx_q[IdxW-1:0]] <= buf_wdata;
  end

  assign bus.deq_rxq    = consume;
  assign bus.word_valid = (state_q == StDrain);
  assign bus.word_data  = (state_q == StDrain) ? buf_q[rd_idx_q[IdxW-1:0]] : 32'h0;
  assign bus.frame_ok   = ok_q;
  assign bus.frame_err  = err_q;
  assign bus.err_code   = err_code_q;
  assign bus.busy       = (state_q != StHunt0);
`ifdef UART_FRAME_ACK_EN
  assign bus.enq_txq  = (state_q == StAck) && !bus.txq_full;
  assign bus.txq_data = (state_q == StAck) ? (ack_ok_q ? 8'h06 : {6'b111000, err_code_q})
                                           : 8'h00;
`else
  assign bus.enq_txq  = 1'b0;
  assign bus.txq_data = 8'h00;
`endif
endmodule
